// File: rtl/mm2st_s2l_if.sv
// Avalon-MM read port plus Avalon-ST source of the short-to-long readout engine.
// master = engine side, slave = RAM/sink side.
interface mm2st_s2l_if #(
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] mm_address;
    logic              mm_chipselect;
    logic              mm_clken;
    logic              mm_write;
    logic [15:0]       mm_readdata;

    logic [31:0]       st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_startofpacket;
    logic              st_endofpacket;
    logic [1:0]        st_empty;

    modport master (
        output mm_address, mm_chipselect, mm_clken, mm_write,
        input  mm_readdata,
        output st_data, st_valid, st_startofpacket, st_endofpacket, st_empty,
        input  st_ready
    );

    modport slave (
        input  mm_address, mm_chipselect, mm_clken, mm_write,
        output mm_readdata,
        input  st_data, st_valid, st_startofpacket, st_endofpacket, st_empty,
        output st_ready
    );
endinterface

// File: rtl/mm2st_s2l.sv
// Reads len 16-bit RAM words over Avalon-MM and emits them packed in pairs on Avalon-ST.
// Optional MM2ST_SEQNUM_EN: prefix each packet with a {16'hBEEF, seq} header beat.
module mm2st_s2l #(
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ADDR_W:0] len,
    output logic            busy,
    output logic            done,
    mm2st_s2l_if.master     bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    typedef struct packed {
        logic odd;
        logic pair0;
        logic last;
    } tag_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t          state, nxt;
    logic [ADDR_W:0] len_q, cnt, len_c;
    logic [1:0]      alloc;
    logic            accept, issue, last_issue;

    logic [RD_LAT:1] vld_pipe;
    tag_t            tag_pipe [RD_LAT:1];
    tag_t            tag_in, rtag;
    logic            rvld;
    logic [15:0]     hi_q;

    beat_t           mem [2];
    logic            wr_ptr, rd_ptr;
    logic [1:0]      occ;
    logic            push, pop, push_data, hdr_push;
    beat_t           push_beat, data_beat, hdr_beat, head;

    // Header beat is pushed straight into the FIFO on the accepting cycle
`ifdef MM2ST_SEQNUM_EN
    localparam bit HDR_EN = 1'b1;
    logic [15:0] seq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 seq <= 16'h0;
        else if (state == S_DONE) seq <= seq + 16'h1;
    end

    assign hdr_push = accept;
    assign hdr_beat = '{data: {16'hBEEF, seq}, sop: 1'b1, eop: (len_c == '0), empty: 2'd0};
`else
    localparam bit HDR_EN = 1'b0;
    assign hdr_push = 1'b0;
    assign hdr_beat = '0;
`endif

    assign len_c  = (len > MAX_LEN) ? MAX_LEN : len;
    // done is registered, so the IDLE cycle carrying it must not accept a start
    assign accept = start && (state == S_IDLE) && !done;

    // A fresh pair needs a free beat slot; the second word of a pair already owns one
    assign issue      = (state == S_READ) && (cnt < len_q) && (cnt[0] || alloc != 2'd2);
    assign last_issue = issue && (cnt == len_q - 1'b1);

    assign tag_in = '{odd: cnt[0], pair0: (cnt[ADDR_W:1] == '0), last: (cnt == len_q - 1'b1)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt  = state;
        busy = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (len_c != '0) nxt = S_READ;
                    else             nxt = HDR_EN ? S_DRAIN : S_DONE;
                end
            end
            S_READ: begin
                busy = 1'b1;
                if (last_issue) nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (alloc == 2'd0) nxt = S_DONE;
            end
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            if (accept) begin
                len_q <= len_c;
                cnt   <= '0;
            end else if (issue) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.mm_address    = cnt[ADDR_W-1:0];
    assign bus.mm_chipselect = issue;
    assign bus.mm_clken      = issue;
    assign bus.mm_write      = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            for (int i = 1; i <= RD_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            vld_pipe[1] <= issue;
            tag_pipe[1] <= tag_in;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign rvld = vld_pipe[RD_LAT];
    assign rtag = tag_pipe[RD_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   hi_q <= 16'h0;
        else if (rvld && !rtag.odd) hi_q <= bus.mm_readdata;
    end

    // Odd word closes a pair; an even word that is also last closes a half-filled beat
    assign push_data = rvld && (rtag.odd || rtag.last);
    always_comb begin
        data_beat.data  = rtag.odd ? {hi_q, bus.mm_readdata} : {bus.mm_readdata, 16'h0};
        data_beat.sop   = !HDR_EN && rtag.pair0;
        data_beat.eop   = rtag.last;
        data_beat.empty = (rtag.last && !rtag.odd) ? 2'd2 : 2'd0;
    end

    assign push      = push_data || hdr_push;
    assign push_beat = hdr_push ? hdr_beat : data_beat;
    assign head      = mem[rd_ptr];
    assign pop       = (occ != 2'd0) && bus.st_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
            alloc  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_beat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ   <= occ + {1'b0, push} - {1'b0, pop};
            alloc <= alloc + {1'b0, (issue && !cnt[0]) || hdr_push} - {1'b0, pop};
        end
    end

    assign bus.st_valid         = (occ != 2'd0);
    assign bus.st_data          = head.data;
    assign bus.st_startofpacket = head.sop;
    assign bus.st_endofpacket   = head.eop;
    assign bus.st_empty         = head.empty;
endmodule
